// File: rtl/axi_pattern_initiator.sv
// AXI3 initiator: writes a seeded incrementing word pattern into a slave memory,
// reads it back, and reports pass/fail with a saturating error count.
module axi_pattern_initiator #(
  parameter int unsigned BW_ADDR    = 32,
  parameter int unsigned BW_DATA    = 128,
  parameter int unsigned BW_AXI_TID = 16,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                    clk,
  input  logic                    rstnn,
  input  logic                    start,
  input  logic [BW_ADDR-1:0]      base_addr,
  input  logic [15:0]             num_burst,
  input  logic [31:0]             seed,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             error_count,
  output logic [BW_AXI_TID-1:0]   sxawid,
  output logic [BW_ADDR-1:0]      sxawaddr,
  output logic [3:0]              sxawlen,
  output logic [2:0]              sxawsize,
  output logic [1:0]              sxawburst,
  output logic                    sxawvalid,
  input  logic                    sxawready,
  output logic [BW_AXI_TID-1:0]   sxwid,
  output logic [BW_DATA-1:0]      sxwdata,
  output logic [BW_DATA/8-1:0]    sxwstrb,
  output logic                    sxwlast,
  output logic                    sxwvalid,
  input  logic                    sxwready,
  input  logic [BW_AXI_TID-1:0]   sxbid,
  input  logic [1:0]              sxbresp,
  input  logic                    sxbvalid,
  output logic                    sxbready,
  output logic [BW_AXI_TID-1:0]   sxarid,
  output logic [BW_ADDR-1:0]      sxaraddr,
  output logic [3:0]              sxarlen,
  output logic [2:0]              sxarsize,
  output logic [1:0]              sxarburst,
  output logic                    sxarvalid,
  input  logic                    sxarready,
  input  logic [BW_AXI_TID-1:0]   sxrid,
  input  logic [BW_DATA-1:0]      sxrdata,
  input  logic [1:0]              sxrresp,
  input  logic                    sxrlast,
  input  logic                    sxrvalid,
  output logic                    sxrready
);

  localparam int unsigned BYTES_PER_BEAT = BW_DATA / 8;
  localparam int unsigned BURST_BYTES    = BURST_LEN * BYTES_PER_BEAT;
  localparam int unsigned ALIGN_BITS     = $clog2(BURST_BYTES);
  localparam int unsigned REPL           = BW_DATA / 32;
  localparam int unsigned BW_BEAT        = 5;

  localparam logic [BW_BEAT-1:0]    LAST_BEAT   = BW_BEAT'(BURST_LEN - 1);
  localparam logic                  SINGLE_BEAT = (BURST_LEN == 32'd1);
  localparam logic [BW_ADDR-1:0]    ADDR_MASK   = ~((BW_ADDR'(1) << ALIGN_BITS) - BW_ADDR'(1));
  localparam logic [BW_ADDR-1:0]    ADDR_STEP   = BW_ADDR'(BURST_BYTES);
  localparam logic [BW_AXI_TID-1:0] ID_VAL      = BW_AXI_TID'(AXI_ID);
  localparam logic [3:0]            LEN_VAL     = 4'(BURST_LEN - 1);
  localparam logic [2:0]            SIZE_VAL    = 3'($clog2(BYTES_PER_BEAT));
  localparam logic [1:0]            BURST_INCR  = 2'b01;
  localparam logic [15:0]           ERR_MAX     = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_FIN  = 3'd6
  } state_e;

  state_e state_q, state_d;

  logic [15:0]           num_q, num_d;
  logic [31:0]           seed_q, seed_d;
  logic [BW_ADDR-1:0]    base_q, base_d;
  logic [BW_ADDR-1:0]    addr_q, addr_d;
  logic [15:0]           burst_cnt_q, burst_cnt_d;
  logic [BW_BEAT-1:0]    beat_q, beat_d;
  logic [31:0]           pat_q, pat_d;
  logic                  wlast_q, wlast_d;
  logic [15:0]           err_q, err_d;
  logic                  pass_q, pass_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [BW_AXI_TID-1:0] id_q, id_d;
  logic [3:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            btype_q, btype_d;
  logic [BW_DATA/8-1:0]  strb_q, strb_d;

  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  last_beat, last_burst, b_err, r_err;
  logic [15:0]           err_inc;
  logic [BW_DATA-1:0]    pat_word;

  assign pat_word   = {REPL{pat_q}};
  assign aw_hs      = awvalid_q & sxawready;
  assign w_hs       = wvalid_q & sxwready;
  assign b_hs       = bready_q & sxbvalid;
  assign ar_hs      = arvalid_q & sxarready;
  assign r_hs       = rready_q & sxrvalid;
  assign last_beat  = (beat_q == LAST_BEAT);
  assign last_burst = ((burst_cnt_q + 16'd1) == num_q);
  assign b_err      = (sxbresp != 2'b00) || (sxbid != ID_VAL);
  assign r_err      = (sxrdata != pat_word) || (sxrresp != 2'b00) ||
                      (sxrid != ID_VAL) || (sxrlast != last_beat);
  assign err_inc    = (err_q == ERR_MAX) ? err_q : err_q + 16'd1;

  // State register
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (num_burst != 16'd0) ? ST_AW : ST_FIN;
      ST_AW:   if (aw_hs) state_d = ST_W;
      ST_W:    if (w_hs && last_beat) state_d = ST_B;
      ST_B:    if (b_hs) state_d = last_burst ? ST_AR : ST_AW;
      ST_AR:   if (ar_hs) state_d = ST_R;
      ST_R:    if (r_hs && last_beat) state_d = last_burst ? ST_FIN : ST_AR;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; handshake flags follow the next state
  always_comb begin
    num_d       = num_q;
    seed_d      = seed_q;
    base_d      = base_q;
    addr_d      = addr_q;
    burst_cnt_d = burst_cnt_q;
    beat_d      = beat_q;
    pat_d       = pat_q;
    wlast_d     = wlast_q;
    err_d       = err_q;
    pass_d      = pass_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    awvalid_d   = (state_d == ST_AW);
    wvalid_d    = (state_d == ST_W);
    bready_d    = (state_d == ST_B);
    arvalid_d   = (state_d == ST_AR);
    rready_d    = (state_d == ST_R);
    id_d        = ID_VAL;
    len_d       = LEN_VAL;
    size_d      = SIZE_VAL;
    btype_d     = BURST_INCR;
    strb_d      = '1;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d       = num_burst;
          seed_d      = seed;
          base_d      = base_addr & ADDR_MASK;
          addr_d      = base_addr & ADDR_MASK;
          burst_cnt_d = 16'd0;
          beat_d      = '0;
          pat_d       = seed;
          wlast_d     = SINGLE_BEAT;
          err_d       = 16'd0;
          pass_d      = 1'b0;
          busy_d      = 1'b1;
        end
      end
      ST_W: begin
        if (w_hs) begin
          pat_d = pat_q + 32'd1;
          if (last_beat) begin
            beat_d  = '0;
            wlast_d = SINGLE_BEAT;
          end else begin
            beat_d  = beat_q + BW_BEAT'(1);
            wlast_d = ((beat_q + BW_BEAT'(1)) == LAST_BEAT);
          end
        end
      end
      ST_B: begin
        if (b_hs) begin
          if (b_err) err_d = err_inc;
          if (last_burst) begin
            // Read phase replays the same address and pattern sequence
            burst_cnt_d = 16'd0;
            addr_d      = base_q;
            pat_d       = seed_q;
          end else begin
            burst_cnt_d = burst_cnt_q + 16'd1;
            addr_d      = addr_q + ADDR_STEP;
          end
        end
      end
      ST_R: begin
        if (r_hs) begin
          if (r_err) err_d = err_inc;
          pat_d = pat_q + 32'd1;
          if (last_beat) begin
            beat_d = '0;
            if (!last_burst) begin
              burst_cnt_d = burst_cnt_q + 16'd1;
              addr_d      = addr_q + ADDR_STEP;
            end
          end else begin
            beat_d = beat_q + BW_BEAT'(1);
          end
        end
      end
      ST_FIN: begin
        done_d = 1'b1;
        pass_d = (err_q == 16'd0);
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      num_q       <= '0;
      seed_q      <= '0;
      base_q      <= '0;
      addr_q      <= '0;
      burst_cnt_q <= '0;
      beat_q      <= '0;
      pat_q       <= '0;
      wlast_q     <= 1'b0;
      err_q       <= '0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      id_q        <= '0;
      len_q       <= '0;
      size_q      <= '0;
      btype_q     <= '0;
      strb_q      <= '0;
    end else begin
      num_q       <= num_d;
      seed_q      <= seed_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      burst_cnt_q <= burst_cnt_d;
      beat_q      <= beat_d;
      pat_q       <= pat_d;
      wlast_q     <= wlast_d;
      err_q       <= err_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      id_q        <= id_d;
      len_q       <= len_d;
      size_q      <= size_d;
      btype_q     <= btype_d;
      strb_q      <= strb_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign error_count = err_q;

  assign sxawid    = id_q;
  assign sxawaddr  = addr_q;
  assign sxawlen   = len_q;
  assign sxawsize  = size_q;
  assign sxawburst = btype_q;
  assign sxawvalid = awvalid_q;

  assign sxwid     = id_q;
  assign sxwdata   = pat_word;
  assign sxwstrb   = strb_q;
  assign sxwlast   = wlast_q;
  assign sxwvalid  = wvalid_q;

  assign sxbready  = bready_q;

  assign sxarid    = id_q;
  assign sxaraddr  = addr_q;
  assign sxarlen   = len_q;
  assign sxarsize  = size_q;
  assign sxarburst = btype_q;
  assign sxarvalid = arvalid_q;

  assign sxrready  = rready_q;

endmodule

// File: tb/tb_axi_pattern_initiator.sv
// Bench for axi_pattern_initiator: memory slave with optional back-pressure,
// and per-run expectations computed from the pattern/addressing rules.
`timescale 1ns/1ps
module tb_axi_pattern_initiator;

  logic         clk = 1'b0;
  logic         rstnn;
  logic         start;
  logic [31:0]  base_addr;
  logic [15:0]  num_burst;
  logic [31:0]  seed;
  logic         busy, done, pass;
  logic [15:0]  error_count;
  logic [15:0]  sxawid, sxwid, sxarid, sxbid, sxrid;
  logic [31:0]  sxawaddr, sxaraddr;
  logic [3:0]   sxawlen, sxarlen;
  logic [2:0]   sxawsize, sxarsize;
  logic [1:0]   sxawburst, sxarburst;
  logic         sxawvalid, sxawready, sxwlast, sxwvalid, sxwready;
  logic [127:0] sxwdata, sxrdata;
  logic [15:0]  sxwstrb;
  logic [1:0]   sxbresp, sxrresp;
  logic         sxbvalid, sxbready, sxarvalid, sxarready;
  logic         sxrlast, sxrvalid, sxrready;

  axi_pattern_initiator dut (
    .clk(clk), .rstnn(rstnn), .start(start), .base_addr(base_addr),
    .num_burst(num_burst), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .error_count(error_count),
    .sxawid(sxawid), .sxawaddr(sxawaddr), .sxawlen(sxawlen), .sxawsize(sxawsize),
    .sxawburst(sxawburst), .sxawvalid(sxawvalid), .sxawready(sxawready),
    .sxwid(sxwid), .sxwdata(sxwdata), .sxwstrb(sxwstrb), .sxwlast(sxwlast),
    .sxwvalid(sxwvalid), .sxwready(sxwready),
    .sxbid(sxbid), .sxbresp(sxbresp), .sxbvalid(sxbvalid), .sxbready(sxbready),
    .sxarid(sxarid), .sxaraddr(sxaraddr), .sxarlen(sxarlen), .sxarsize(sxarsize),
    .sxarburst(sxarburst), .sxarvalid(sxarvalid), .sxarready(sxarready),
    .sxrid(sxrid), .sxrdata(sxrdata), .sxrresp(sxrresp), .sxrlast(sxrlast),
    .sxrvalid(sxrvalid), .sxrready(sxrready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Slave-side knobs (written by the stimulus) and logs (written by the slave)
  bit           bp_en = 1'b0;
  logic [1:0]   bresp_mode = 2'b00;
  int           corrupt_req = 0;
  int           corrupt_done = 0;
  int           stable_bad = 0;
  int           n_valid = 0;
  logic [127:0] mem [logic [31:0]];
  logic [127:0] w_data_q [$];
  logic [31:0]  w_addr_q [$];
  logic         w_last_q [$];
  logic [31:0]  aw_q [$];
  logic [31:0]  ar_q [$];

  // Memory slave, one outstanding transaction; decisions made at negedge
  initial begin : slave
    logic [31:0]  waddr, raddr, aw_hold, ar_hold, a;
    logic [127:0] w_hold;
    logic         wl_hold;
    int           widx, ridx;
    bit           b_pend, r_act, b_acc, r_acc, aw_wait, w_wait, ar_wait;
    waddr = '0; raddr = '0; widx = 0; ridx = 0;
    b_pend = 0; r_act = 0; b_acc = 0; r_acc = 0;
    aw_wait = 0; w_wait = 0; ar_wait = 0;
    aw_hold = '0; ar_hold = '0; w_hold = '0; wl_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstnn) begin
        sxawready = 1'b0; sxwready = 1'b0; sxarready = 1'b0;
        sxbvalid = 1'b0; sxbresp = 2'b00; sxbid = '0;
        sxrvalid = 1'b0; sxrdata = '0; sxrresp = 2'b00; sxrid = '0; sxrlast = 1'b0;
        b_pend = 0; r_act = 0; b_acc = 0; r_acc = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; widx = 0; ridx = 0;
      end else begin
        if (aw_wait && (!sxawvalid || sxawaddr != aw_hold)) stable_bad++;
        if (w_wait && (!sxwvalid || sxwdata != w_hold || sxwlast != wl_hold)) stable_bad++;
        if (ar_wait && (!sxarvalid || sxaraddr != ar_hold)) stable_bad++;
        if (sxawvalid || sxwvalid || sxarvalid) n_valid++;

        sxawready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        aw_wait = sxawvalid && !sxawready; aw_hold = sxawaddr;
        if (sxawvalid && sxawready) begin
          waddr = sxawaddr; widx = 0; aw_q.push_back(sxawaddr);
        end

        sxwready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        w_wait = sxwvalid && !sxwready; w_hold = sxwdata; wl_hold = sxwlast;
        if (sxwvalid && sxwready) begin
          a = waddr + 32'(widx) * 32'd16;
          mem[a] = sxwdata;
          w_data_q.push_back(sxwdata); w_addr_q.push_back(a); w_last_q.push_back(sxwlast);
          widx++;
          if (widx == 16) b_pend = 1;
        end

        if (b_acc) begin sxbvalid = 1'b0; b_acc = 0; end
        if (!sxbvalid && b_pend && (!bp_en || $urandom_range(0, 1) == 1)) begin
          sxbvalid = 1'b1; sxbresp = bresp_mode; sxbid = '0;
        end
        if (sxbvalid && sxbready) begin b_acc = 1; b_pend = 0; end

        sxarready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        ar_wait = sxarvalid && !sxarready; ar_hold = sxaraddr;
        if (sxarvalid && sxarready) begin
          raddr = sxaraddr; ridx = 0; r_act = 1; ar_q.push_back(sxaraddr);
          if (corrupt_req != corrupt_done) begin
            if (mem.exists(32'h1010)) mem[32'h1010] = mem[32'h1010] ^ 128'h1;
            corrupt_done = corrupt_req;
          end
        end

        if (r_acc) begin sxrvalid = 1'b0; r_acc = 0; end
        if (r_act && !sxrvalid && (!bp_en || $urandom_range(0, 1) == 1)) begin
          a = raddr + 32'(ridx) * 32'd16;
          sxrvalid = 1'b1;
          sxrdata  = mem.exists(a) ? mem[a] : '0;
          sxrlast  = (ridx == 15);
          sxrresp  = 2'b00;
          sxrid    = '0;
        end
        if (sxrvalid && sxrready) begin
          r_acc = 1; ridx++;
          if (ridx == 16) r_act = 0;
        end
      end
    end
  end

  // One complete run; expectations come from the addressing/pattern rules
  task automatic run(input int unsigned nb, input logic [31:0] sd, input logic [31:0] base,
                     input bit bp, input logic [1:0] bresp, input bit corrupt, input string tag);
    int           w0, a0, r0, sb0, nv0, cyc, exp_err, bad_d, bad_a, bad_l, bad_aw, bad_ar;
    bit           seen;
    logic [31:0]  ab;
    logic [127:0] exp_w;
    bp_en = bp; bresp_mode = bresp;
    if (corrupt) corrupt_req++;
    w0 = w_data_q.size(); a0 = aw_q.size(); r0 = ar_q.size();
    sb0 = stable_bad; nv0 = n_valid;
    ab = base & 32'hFFFF_FF00;
    exp_err = (bresp != 2'b00) ? int'(nb) : 0;
    if (corrupt && ((32'h1010 - ab) < 32'(nb) * 32'd256)) exp_err++;

    @(negedge clk);
    start = 1'b1; num_burst = 16'(nb); seed = sd; base_addr = base;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    cyc = 1; seen = done;
    while (!seen && cyc < 6000) begin
      start = (cyc == 8);
      @(negedge clk);
      cyc++; seen = done;
    end
    start = 1'b0;
    chk({tag, ".done"}, 64'(seen), 64'd1);
    if (nb == 0) chk({tag, ".latency"}, 64'(cyc), 64'd2);
    chk({tag, ".err"}, 64'(error_count), 64'(exp_err));
    chk({tag, ".pass"}, 64'(pass), 64'(exp_err == 0));
    chk({tag, ".busy_end"}, 64'(busy), 64'd0);
    chk({tag, ".aw_cnt"}, 64'(aw_q.size() - a0), 64'(nb));
    chk({tag, ".w_cnt"}, 64'(w_data_q.size() - w0), 64'(nb * 16));
    chk({tag, ".ar_cnt"}, 64'(ar_q.size() - r0), 64'(nb));
    bad_d = 0; bad_a = 0; bad_l = 0; bad_aw = 0; bad_ar = 0;
    for (int k = 0; k < int'(nb) * 16; k++) begin
      if (w0 + k < w_data_q.size()) begin
        exp_w = {4{sd + 32'(k)}};
        if (w_data_q[w0 + k] != exp_w) bad_d++;
        if (w_addr_q[w0 + k] != ab + 32'(k) * 32'd16) bad_a++;
        if (w_last_q[w0 + k] != ((k % 16) == 15)) bad_l++;
      end
    end
    for (int n = 0; n < int'(nb); n++) begin
      if (a0 + n < aw_q.size() && aw_q[a0 + n] != ab + 32'(n) * 32'd256) bad_aw++;
      if (r0 + n < ar_q.size() && ar_q[r0 + n] != ab + 32'(n) * 32'd256) bad_ar++;
    end
    chk({tag, ".wdata"}, 64'(bad_d), 64'd0);
    chk({tag, ".waddr"}, 64'(bad_a), 64'd0);
    chk({tag, ".wlast"}, 64'(bad_l), 64'd0);
    chk({tag, ".awaddr"}, 64'(bad_aw), 64'd0);
    chk({tag, ".araddr"}, 64'(bad_ar), 64'd0);
    chk({tag, ".stable"}, 64'(stable_bad - sb0), 64'd0);
    if (nb == 0) chk({tag, ".no_valid"}, 64'(n_valid - nv0), 64'd0);
    @(negedge clk);
    chk({tag, ".pass_hold"}, 64'(pass), 64'(exp_err == 0));
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int           t1w, cyc;
    logic [127:0] w0word;
    rstnn = 1'b1; start = 1'b0; base_addr = '0; num_burst = '0; seed = '0;
    #1 rstnn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.ctl", 64'({busy, done, pass, sxawvalid, sxwvalid, sxbready, sxarvalid, sxrready}), 64'd0);
    chk("rst.err", 64'(error_count), 64'd0);
    chk("rst.fields", 64'({sxawlen, sxawsize, sxawburst, sxarlen, sxwlast, sxwstrb}), 64'd0);
    rstnn = 1'b1;
    @(negedge clk);
    chk("cfg.aw", 64'({sxawlen, sxawsize, sxawburst}), 64'({4'd15, 3'd4, 2'b01}));
    chk("cfg.ar", 64'({sxarlen, sxarsize, sxarburst}), 64'({4'd15, 3'd4, 2'b01}));
    chk("cfg.strb", 64'(sxwstrb), 64'hFFFF);

    t1w = w_data_q.size();
    run(2, 32'h10, 32'h1000, 1'b0, 2'b00, 1'b0, "t1");
    w0word = (w_data_q.size() > t1w) ? w_data_q[t1w] : '0;
    chk("t1.wdata0_lo", 64'(w0word[63:0]), 64'h0000_0010_0000_0010);
    chk("t1.wdata0_hi", 64'(w0word[127:64]), 64'h0000_0010_0000_0010);

    for (int i = 0; i < 6; i++)
      run($urandom_range(1, 4), $urandom(), $urandom(), 1'b1, 2'b00, 1'b0, "rnd");
    run(2, $urandom(), 32'hFFFF_FF80, 1'b1, 2'b00, 1'b0, "wrap");
    run(2, 32'h55, 32'h1000, 1'b0, 2'b00, 1'b1, "t3");
    run(0, 32'h99, 32'h4000, 1'b0, 2'b00, 1'b0, "t4");
    run(2, 32'h77, 32'h2000, 1'b0, 2'b10, 1'b0, "t5");

    // Reset in the middle of the write phase
    t1w = w_data_q.size();
    bp_en = 1'b0; bresp_mode = 2'b00;
    @(negedge clk);
    start = 1'b1; num_burst = 16'd2; seed = 32'hABCD; base_addr = 32'h3000;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (w_data_q.size() < t1w + 5 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("t6.w_started", 64'(w_data_q.size() >= t1w + 5), 64'd1);
    rstnn = 1'b0;
    #1;
    chk("t6.rst_valid", 64'({sxawvalid, sxwvalid, sxbready, sxarvalid, sxrready}), 64'd0);
    chk("t6.rst_status", 64'({busy, done, pass, error_count}), 64'd0);
    repeat (2) @(negedge clk);
    rstnn = 1'b1;
    run(2, 32'h5EED, 32'h3000, 1'b1, 2'b00, 1'b0, "t6b");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
